// File: rtl/pong_ctrl_pkg.sv
// Shared types and constants for the pong ball horizontal controller.
package pong_ctrl_pkg;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    PLAY    = 2'd1,
    ATTRACT = 2'd2
  } ctrl_state_t;

  // Velocity load codes {ba,aa} for the ball horizontal counter.
  localparam logic [1:0] VEL_HOLD = 2'b00;
  localparam logic [1:0] VEL_SLOW = 2'b01;
  localparam logic [1:0] VEL_MED  = 2'b10;
  localparam logic [1:0] VEL_FAST = 2'b11;

  // Speed step for a rally: the ball speeds up as the hit count grows.
  function automatic logic [1:0] playVelocity(input logic [3:0] hitCount,
                                              input int medHits,
                                              input int fastHits);
    if (int'(hitCount) < medHits) begin
      return VEL_SLOW;
    end else if (int'(hitCount) < fastHits) begin
      return VEL_MED;
    end
    return VEL_FAST;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Loadable down-counter stepped by a frame strobe; sticks at zero.
module frame_down_counter #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_loadValue,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  // A load always wins over a decrement so a reload on a frame edge takes its full value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= RESET_VALUE;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/ball_horizontal_control.sv
// Ball horizontal motion sequencer: serve hold, direction and speed code.
module ball_horizontal_control
  import pong_ctrl_pkg::*;
#(
  parameter int MED_HITS           = 4,
  parameter int FAST_HITS          = 12,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int HIT_LOCKOUT_FRAMES = 2
) (
  input  logic       clk7_159,
  input  logic       reset,
  input  logic       _attract,
  input  logic       vblank_start,
  input  logic       hit,
  input  logic       hit_side,
  input  logic       miss,
  input  logic       miss_side,
  output logic       aa,
  output logic       ba,
  output logic       move_right,
  output logic       serve,
  output logic [3:0] hit_count
);

  ctrl_state_t r_state;
  logic        r_serve;
  logic [1:0]  r_vel;
  logic        r_moveRight;
  logic [3:0]  r_hitCount;
  logic        r_hitQ;

  logic        w_rise;
  logic        w_playMiss;
  logic        w_hitTaken;
  logic        w_delayLoad;
  logic        w_delayDec;
  logic        w_launch;
  logic [7:0]  w_delayCount;
  logic        w_delayZero;
  logic        w_lockLoad;
  logic [3:0]  w_lockLoadValue;
  logic        w_lockDec;
  logic [3:0]  w_lockCount;
  logic        w_lockZero;
  logic [3:0]  w_nextHitCount;

  assign w_rise         = hit & ~r_hitQ;
  assign w_playMiss     = (r_state == PLAY) && _attract && miss;
  // A rise is acted on in PLAY or attract mode, only outside lockout, and never alongside a miss.
  assign w_hitTaken     = w_rise && w_lockZero && !miss &&
                          (!_attract || (r_state == PLAY));
  assign w_nextHitCount = (r_hitCount == 4'hF) ? 4'hF : (r_hitCount + 4'd1);

  assign w_delayLoad    = ((r_state == ATTRACT) && _attract) || w_playMiss;
  assign w_delayDec     = (r_state == WAIT) && _attract && vblank_start;
  assign w_launch       = w_delayDec && ((w_delayCount == 8'd1) || w_delayZero);

  assign w_lockLoad      = w_hitTaken || w_playMiss;
  assign w_lockLoadValue = w_playMiss ? 4'd0 : 4'(HIT_LOCKOUT_FRAMES);
  assign w_lockDec       = vblank_start && (w_lockCount != 4'd0);

  frame_down_counter #(
    .WIDTH       (8),
    .RESET_VALUE (8'(SERVE_DELAY_FRAMES))
  ) u_serveDelay (
    .clk         (clk7_159),
    .reset       (reset),
    .i_load      (w_delayLoad),
    .i_loadValue (8'(SERVE_DELAY_FRAMES)),
    .i_dec       (w_delayDec),
    .o_count     (w_delayCount),
    .o_zero      (w_delayZero)
  );

  frame_down_counter #(
    .WIDTH       (4),
    .RESET_VALUE (4'd0)
  ) u_hitLockout (
    .clk         (clk7_159),
    .reset       (reset),
    .i_load      (w_lockLoad),
    .i_loadValue (w_lockLoadValue),
    .i_dec       (w_lockDec),
    .o_count     (w_lockCount),
    .o_zero      (w_lockZero)
  );

  // Controller FSM with registered serve, velocity code, direction and hit count; attract overrides all states.
  always_ff @(posedge clk7_159 or posedge reset) begin
    if (reset) begin
      r_state     <= WAIT;
      r_serve     <= 1'b1;
      r_vel       <= VEL_HOLD;
      r_moveRight <= 1'b1;
      r_hitCount  <= 4'd0;
      r_hitQ      <= 1'b0;
    end else begin
      r_hitQ <= hit;
      if (!_attract) begin
        r_state    <= ATTRACT;
        r_serve    <= 1'b0;
        r_vel      <= VEL_MED;
        r_hitCount <= 4'd0;
        if (miss) begin
          r_moveRight <= ~miss_side;
        end else if (w_hitTaken) begin
          r_moveRight <= ~hit_side;
        end
      end else begin
        unique case (r_state)
          ATTRACT: begin
            r_state    <= WAIT;
            r_serve    <= 1'b1;
            r_vel      <= VEL_HOLD;
            r_hitCount <= 4'd0;
          end
          WAIT: begin
            r_serve <= 1'b1;
            r_vel   <= VEL_HOLD;
            if (w_launch) begin
              r_state <= PLAY;
              r_serve <= 1'b0;
              r_vel   <= playVelocity(r_hitCount, MED_HITS, FAST_HITS);
            end
          end
          PLAY: begin
            if (miss) begin
              r_state     <= WAIT;
              r_serve     <= 1'b1;
              r_vel       <= VEL_HOLD;
              r_hitCount  <= 4'd0;
              r_moveRight <= miss_side;
            end else if (w_hitTaken) begin
              r_moveRight <= ~hit_side;
              r_hitCount  <= w_nextHitCount;
              r_vel       <= playVelocity(w_nextHitCount, MED_HITS, FAST_HITS);
            end
          end
          default: begin
            r_state <= WAIT;
          end
        endcase
      end
    end
  end

  assign aa         = r_vel[0];
  assign ba         = r_vel[1];
  assign move_right = r_moveRight;
  assign serve      = r_serve;
  assign hit_count  = r_hitCount;

endmodule
